// File: rtl/rr_arbiter8_pkg.sv
// Shared types and constants for the eight-way round-robin arbiter.
package arb_pkg;
    localparam int N_REQ  = 8;
    localparam int IDX_W  = 3;
    localparam int HOLD_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_e;
endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
// Handshake: req[i] is a level held by requester i until it sees itself granted
// (gnt_valid=1 with gnt_idx=i) and finishes; done is sampled only while granted.
interface rr_arbiter8_if;
    logic [arb_pkg::N_REQ-1:0] req;
    logic                      done;
    logic [arb_pkg::IDX_W-1:0] gnt_idx;
    logic                      gnt_valid;
    logic                      timeout;

    modport master (output req, output done, input gnt_idx, input gnt_valid, input timeout);
    modport slave  (input req, input done, output gnt_idx, output gnt_valid, output timeout);
endinterface

// File: rtl/rr_arbiter8_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping mod 8.
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   enc;

    always_comb begin
        dbl = {req, req};
        // rot[i] corresponds to requester (ptr + i) mod 8
        rot = dbl[ptr +: N_REQ];
        enc = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) enc = IDX_W'(i);
        end
        idx = enc + ptr;
        any = |req;
    end
endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter with registered grant index, hold timeout and a
// one-cycle break-before-make gap between consecutive grants.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    rr_arbiter8_if.slave     bus,
    output arb_state_e       dbg_state,
    output logic [IDX_W-1:0] dbg_ptr
);
    localparam bit               TO_EN     = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    arb_state_e        state;
    logic [IDX_W-1:0]  ptr;
    logic [HOLD_W-1:0] hold_cnt;
    logic [IDX_W-1:0]  gnt_idx_q;
    logic              gnt_valid_q;
    logic              timeout_q;

    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic              owner_req;
    logic              to_hit;
    logic              rel;

    rr_pick u_pick (
        .req (bus.req),
        .ptr (ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        owner_req = bus.req[gnt_idx_q];
        to_hit    = TO_EN && (hold_cnt == HOLD_LAST);
        rel       = bus.done || !owner_req || to_hit;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            hold_cnt    <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        gnt_idx_q   <= pick_idx;
                        gnt_valid_q <= 1'b1;
                        hold_cnt    <= '0;
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    if (rel) begin
                        gnt_valid_q <= 1'b0;
                        ptr         <= gnt_idx_q + 1'b1;
                        // only flag a forced release, not a coincident normal one
                        timeout_q   <= to_hit && !bus.done && owner_req;
                        state       <= GAP;
                    end else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state       <= IDLE;
                    gnt_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt_idx   = gnt_idx_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.timeout   = timeout_q;
    assign dbg_state     = state;
    assign dbg_ptr       = ptr;
endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
Eight-requester round-robin arbiter. It produces a registered 3-bit grant index plus a valid flag. It sits directly upstream of three_eight_decoder, which turns gnt_idx into the one-hot grant bus; downstream logic qualifies that bus with gnt_valid. Grants are held until the winner finishes or a hold timeout fires. A mandatory idle cycle between grants gives break-before-make.

Parameters:
N_REQ, 8, number of requesters; fixed at 8 to match the 3-bit decoder input.
IDX_W, 3, width of gnt_idx.
MAX_HOLD, 16, maximum cycles a grant may be held; 0 disables the timeout. Legal range 0..255.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active-low
req  input  8  request vector; bit i = requester i
done  input  1  current owner finished; single-cycle or level, sampled only in GRANT
gnt_idx  output  3  index of the granted requester; drives decoder input a
gnt_valid  output  1  grant active; the decoder output is meaningless when low
timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n). All state updates occur on the clk rising edge.
- Reset values:
  - gnt_idx=0, gnt_valid=0, timeout=0
  - state=IDLE, hold_cnt=0
  - ptr=0 (search start position)
- Reset asserted mid-grant: the next edge clears all state with no release pulse and no timeout pulse.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If req!=0, pick the first set bit scanning ptr, ptr+1, ... mod 8.
  - Register the pick into gnt_idx, set gnt_valid=1, go to GRANT, clear hold_cnt.
  - Latency: req seen at edge k gives gnt_valid=1 after edge k.
  - If req==0, stay in IDLE; gnt_idx holds its last value.
- GRANT: each cycle, evaluate release = done OR !req[gnt_idx] OR (MAX_HOLD!=0 AND hold_cnt==MAX_HOLD-1).
  - No release: hold_cnt increments, saturating at 255; gnt_idx is stable.
  - Release: at the same edge, gnt_valid=0, ptr=gnt_idx+1 (7 wraps to 0), go to GAP.
  - timeout=1 for that one cycle only if the timeout term alone caused the release. Any coincidence with done or a request drop gives timeout=0.
- GAP: exactly one cycle with gnt_valid=0, then IDLE. Requests arriving in GAP are arbitrated in IDLE, so the minimum grant-to-grant spacing is 3 cycles.
- Boundary conditions:
  - done in IDLE or GAP is ignored.
  - Requests changing during GRANT do not affect gnt_idx.
  - A requester dropping req and re-raising it in the same cycle is treated as continuous.
  - All 8 requesting continuously: grants rotate 0,1,...,7,0 with strict fairness; no requester waits more than 7 grants.
  - MAX_HOLD=1: release after 1 cycle in GRANT.
- Arithmetic and width:
  - ptr is 3-bit and wraps naturally.
  - hold_cnt is 8-bit.
  - MAX_HOLD is compared at hold_cnt width.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package arb_pkg holds:
  - N_REQ and IDX_W localparams
  - state enum (IDLE=2'd0, GRANT=2'd1, GAP=2'd2)
  - HOLD_W=8
- One combinational sub-module, rr_pick (inputs req[7:0], ptr[2:0]; outputs idx[2:0], any).
  - Implementation: rotate right by ptr, fixed-priority LSB-first encode, add ptr back mod 8.
  - rr_pick is unit-tested exhaustively (2048 vectors) before integration.

Test Plan:
1. Reset, then req=8'b0000_0100, done after 3 cycles -> gnt_valid rises 1 cycle after req with gnt_idx=2; after done, 1 GAP cycle, ptr=3.
2. req=8'hFF held, done pulsed every 2nd GRANT cycle -> gnt_idx sequence 0,1,2,3,4,5,6,7,0 with a one-cycle gnt_valid=0 gap between each.
3. ptr=6 (after granting 5), req=8'b0010_0001 -> gnt_idx=0 (wrap past 7), then 5 on the next round.
4. MAX_HOLD=16, req=8'h08 held, no done -> gnt_valid high exactly 16 cycles, timeout pulses 1 cycle at release, then gnt_idx=3 is re-granted after GAP+IDLE.
5. During a grant to 4, drop req[4] the same cycle done=1 -> single release, timeout=0, no double GAP.
6. rst_n=0 for one edge mid-GRANT with gnt_idx=5 -> the next cycle shows gnt_valid=0, gnt_idx=0, timeout=0; with req=8'hFF the next grant is 0.
